// File: rtl/throughput_reporter_pkg.sv
// rtl/throughput_reporter_pkg.sv - ASCII constants and FSM state encoding for throughput_reporter.
// ST_SEQ exists only when THROUGHPUT_REPORT_SEQ_EN is defined.
package throughput_reporter_pkg;

    localparam logic [7:0] CHR_O    = 8'h4F;
    localparam logic [7:0] CHR_P    = 8'h50;
    localparam logic [7:0] CHR_S    = 8'h53;
    localparam logic [7:0] CHR_EQ   = 8'h3D;
    localparam logic [7:0] CHR_HASH = 8'h23;
    localparam logic [7:0] CHR_SP   = 8'h20;
    localparam logic [7:0] CHR_CR   = 8'h0D;
    localparam logic [7:0] CHR_LF   = 8'h0A;
    localparam logic [7:0] CHR_0    = 8'h30;
    localparam logic [7:0] CHR_A    = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
`ifdef THROUGHPUT_REPORT_SEQ_EN
        ST_SEQ    = 3'd1,
`endif
        ST_PREFIX = 3'd2,
        ST_DIGITS = 3'd3,
        ST_CR     = 3'd4,
        ST_LF     = 3'd5
    } state_e;

endpackage

// File: rtl/throughput_reporter_if.sv
// rtl/throughput_reporter_if.sv - byte valid/ready link from the reporter to the UART transmitter.
interface throughput_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/throughput_reporter_hex_nibble_ascii.sv
// rtl/throughput_reporter_hex_nibble_ascii.sv - combinational 4-bit value to uppercase ASCII hex digit.
module hex_nibble_ascii
    import throughput_reporter_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);
    assign o_ascii = (i_nibble < 4'd10) ? (CHR_0 + {4'h0, i_nibble})
                                        : (CHR_A - 8'd10 + {4'h0, i_nibble});
endmodule

// File: rtl/throughput_reporter.sv
// rtl/throughput_reporter.sv - streams each captured window op count as "OPS=XXXXXXXX\r\n".
// THROUGHPUT_REPORT_SEQ_EN prepends an 8-bit window sequence "#hh " to each line.
module throughput_reporter
    import throughput_reporter_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   window_done,
    input  logic [COUNT_WIDTH-1:0] ops_result,
    throughput_reporter_if.master  tx,
    output logic                   busy,
    output logic [DROP_WIDTH-1:0]  dropped_count
);
    localparam int NIBBLES = COUNT_WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 4) ? $clog2(NIBBLES) : 2;
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NIBBLES - 1);

    state_e                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [COUNT_WIDTH-1:0] r_cap;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic [DROP_WIDTH-1:0]  r_dropped;
`ifdef THROUGHPUT_REPORT_SEQ_EN
    logic [7:0]             r_seq;
`endif

    logic             w_hs;
    logic             w_lf_done;
    logic             w_capture;
    logic             w_drop;
    logic [IDX_W:0]   w_dig_sel;
    logic [3:0]       w_nibble;
    logic [7:0]       w_nib_ascii;

    assign w_hs      = r_tx_valid && tx.tx_ready;
    assign w_lf_done = (r_state == ST_LF) && w_hs;
    assign w_capture = window_done && enable && ((r_state == ST_IDLE) || w_lf_done);
    assign w_drop    = window_done && (r_state != ST_IDLE) && !w_lf_done;

    // The nibble mux selects the digit that will be presented after the current handshake.
    assign w_dig_sel = (r_state == ST_DIGITS) ? ({1'b0, r_idx} + (IDX_W + 1)'(1)) : '0;

    always_comb begin
        w_nibble = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (w_dig_sel == (IDX_W + 1)'(k)) begin
                w_nibble = r_cap[COUNT_WIDTH - 1 - 4 * k -: 4];
            end
        end
`ifdef THROUGHPUT_REPORT_SEQ_EN
        if (r_state == ST_SEQ) begin
            w_nibble = (r_idx == '0) ? r_seq[7:4] : r_seq[3:0];
        end
`endif
    end

    hex_nibble_ascii u_hex (
        .i_nibble (w_nibble),
        .o_ascii  (w_nib_ascii)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cap      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_dropped  <= '0;
`ifdef THROUGHPUT_REPORT_SEQ_EN
            r_seq      <= 8'h00;
`endif
        end else begin
            if (w_drop && (r_dropped != '1)) begin
                r_dropped <= r_dropped + DROP_WIDTH'(1);
            end

            if (w_capture) begin
                r_cap      <= ops_result;
                r_idx      <= '0;
                r_tx_valid <= 1'b1;
`ifdef THROUGHPUT_REPORT_SEQ_EN
                r_state    <= ST_SEQ;
                r_tx_data  <= CHR_HASH;
`else
                r_state    <= ST_PREFIX;
                r_tx_data  <= CHR_O;
`endif
            end else if (w_hs) begin
                case (r_state)
`ifdef THROUGHPUT_REPORT_SEQ_EN
                    ST_SEQ: begin
                        if (r_idx == IDX_W'(3)) begin
                            r_state   <= ST_PREFIX;
                            r_idx     <= '0;
                            r_tx_data <= CHR_O;
                            r_seq     <= r_seq + 8'd1;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            r_tx_data <= (r_idx == IDX_W'(2)) ? CHR_SP : w_nib_ascii;
                        end
                    end
`endif
                    ST_PREFIX: begin
                        case (r_idx)
                            IDX_W'(0): r_tx_data <= CHR_P;
                            IDX_W'(1): r_tx_data <= CHR_S;
                            IDX_W'(2): r_tx_data <= CHR_EQ;
                            default:   r_tx_data <= w_nib_ascii;
                        endcase
                        if (r_idx == IDX_W'(3)) begin
                            r_state <= ST_DIGITS;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end
                    ST_DIGITS: begin
                        if (r_idx == LAST_DIGIT) begin
                            r_state   <= ST_CR;
                            r_tx_data <= CHR_CR;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            r_tx_data <= w_nib_ascii;
                        end
                    end
                    ST_CR: begin
                        r_state   <= ST_LF;
                        r_tx_data <= CHR_LF;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx.tx_data    = r_tx_data;
    assign tx.tx_valid   = r_tx_valid;
    assign busy          = (r_state != ST_IDLE);
    assign dropped_count = r_dropped;

endmodule

// File: tb/tb_throughput_reporter.sv
// tb/tb_throughput_reporter.sv - randomized self-checking bench for throughput_reporter.
module tb_throughput_reporter;

`ifdef THROUGHPUT_REPORT_SEQ_EN
    localparam int FRAME_LEN = 18;
`else
    localparam int FRAME_LEN = 14;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        window_done;
    logic [31:0] ops_result;
    logic        busy;
    logic [15:0] dropped_count;

    throughput_reporter_if tx_if ();

    throughput_reporter #(.COUNT_WIDTH(32), .DROP_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .window_done   (window_done),
        .ops_result    (ops_result),
        .tx            (tx_if.master),
        .busy          (busy),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         rx_total = 0;
    int         exp_drop = 0;
    logic [7:0] model_seq = 8'h00;
    int         ready_mode = 0;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    task automatic push_frame(input logic [31:0] v);
`ifdef THROUGHPUT_REPORT_SEQ_EN
        exp_q.push_back(8'h23);
        exp_q.push_back(hexc(int'(model_seq) / 16));
        exp_q.push_back(hexc(int'(model_seq) % 16));
        exp_q.push_back(8'h20);
        model_seq = model_seq + 8'd1;
`endif
        exp_q.push_back("O");
        exp_q.push_back("P");
        exp_q.push_back("S");
        exp_q.push_back("=");
        for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(int'((v >> (4 * i)) & 32'hF)));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       tx_if.tx_ready = 1'b1;
                1:       tx_if.tx_ready = (cyc % 3 == 0);
                default: tx_if.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pv && !pr) begin
                check("hold_valid", tx_if.tx_valid, 1);
                check("hold_data", tx_if.tx_data, pd);
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_q.size() == 0) check("byte_expected", 0, 1);
                else check("byte", tx_if.tx_data, exp_q.pop_front());
                rx_total <= rx_total + 1;
            end
            pv <= tx_if.tx_valid;
            pr <= tx_if.tx_ready;
            pd <= tx_if.tx_data;
        end else begin
            pv <= 1'b0;
        end
    end

    task automatic pulse_now(input logic [31:0] v, input logic en, output bit captured);
        bit cap;
        bit drp;
        cap = en && (exp_q.size() == 0);
        drp = (exp_q.size() != 0);
        window_done = 1'b1;
        enable = en;
        ops_result = v;
        @(posedge clk);
        #1;
        window_done = 1'b0;
        ops_result = $urandom();
        if (cap) begin
            push_frame(v);
            check("first_valid", tx_if.tx_valid, 1);
            check("first_byte", tx_if.tx_data, exp_q[0]);
        end
        if (drp && exp_drop < 65535) exp_drop++;
        captured = cap;
    endtask

    task automatic pulse(input logic [31:0] v, input logic en, output bit captured);
        @(negedge clk);
        #1;
        pulse_now(v, en, captured);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && busy === 1'b0) done = 1;
        end
        check({tag, "_idle"}, done, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cap;
        int n;
        int base;
        int captures;
        bit ok;

        rst_n = 1'b0;
        enable = 1'b0;
        window_done = 1'b0;
        ops_result = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tx_if.tx_valid, 0);
        check("rst_data", tx_if.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", dropped_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;

        // 1: continuous ready, back-to-back bytes
        ready_mode = 0;
        pulse(32'h0001ABCD, 1'b1, cap);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        check("t1_busy_cycles", n, FRAME_LEN);
        check("t1_all_bytes", exp_q.size(), 0);

        // 2: throttled ready
        ready_mode = 1;
        pulse(32'h0001ABCD, 1'b1, cap);
        wait_idle("t2");
        check("t2_drop", dropped_count, exp_drop);

        // 3: overrun
        ready_mode = 2;
        pulse(32'hFFFFFFFF, 1'b1, cap);
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(posedge clk);
            pulse($urandom(), 1'b1, cap);
        end
        wait_idle("t3");
        check("t3_drop", dropped_count, exp_drop);
        check("t3_drop_is3", exp_drop, 3);

        // 4: capture on the LF handshake cycle
        ready_mode = 0;
        pulse(32'h13572468, 1'b1, cap);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) ok = 1;
        end
        check("t4_reach_lf", ok, 1);
        check("t4_lf_on_bus", tx_if.tx_data, 8'h0A);
        pulse_now(32'h00000010, 1'b1, cap);
        wait_idle("t4");
        check("t4_drop", dropped_count, exp_drop);

        // 5: reset mid-frame after the 6th byte
        ready_mode = 0;
        base = rx_total;
        pulse(32'hDEADBEEF, 1'b1, cap);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rx_total == base + 6) ok = 1;
        end
        check("t5_six_bytes", ok, 1);
        @(posedge clk);
        #1;
        check("t5_valid_before", tx_if.tx_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", tx_if.tx_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_drop", dropped_count, 0);
        exp_q.delete();
        exp_drop = 0;
        model_seq = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse(32'hA5A50F0F, 1'b1, cap);
        wait_idle("t5");

        // disabled pulse in idle: no frame, no drop
        pulse(32'h12345678, 1'b0, cap);
        repeat (3) @(negedge clk);
        check("dis_busy", busy, 0);
        check("dis_drop", dropped_count, exp_drop);

        // 6: randomized windows, gaps, enable and ready
        ready_mode = 2;
        captures = 0;
        for (int i = 0; i < 3000 && captures < 257; i++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            pulse($urandom(), 1'($urandom_range(0, 7) != 0), cap);
            if (cap) captures++;
        end
        wait_idle("t6");
        check("t6_drop", dropped_count, exp_drop);
        check("t6_valid_end", tx_if.tx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
